vram_arbiter: RTL and testbench

- Shares one single-port video RAM between two requesters:
  - the display scan-out fetcher, which reads pixels for posx/posy while the raster is active;
  - the draw engine, which reads and writes pixels.
- Sits between the raster position/active-region logic and the VRAM.
- Display has priority during active video, draw has priority during blanking.
- A starvation counter guarantees the draw engine forward progress.

---
 rtl/vga_pkg.sv | 13 +
 rtl/vram_rd_tag_pipe.sv | 20 ++
 rtl/vram_arbiter.sv | 81 ++++++++
 tb/tb_vram_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: arbiter states, read-owner tag encoding and default VRAM widths
package vga_pkg;
  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_FORCE  = 2'd2;
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_DRAW = 2'd2
  } tag_t;
endpackage

// File: rtl/vram_rd_tag_pipe.sv
// vram_rd_tag_pipe: delays read-owner tags so each rvalid lines up with its returning data
module vram_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] tag,
  output logic       disp_rvalid,
  output logic       draw_rvalid
);
  logic [2*RD_LAT+1:0] sr;
  // stage 0 is loaded with the VRAM command; the oldest stage marks the data-return cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[2*RD_LAT-1:0], tag};
  assign disp_rvalid = sr[2*RD_LAT+1 -: 2] == TAG_DISP;
  assign draw_rvalid = sr[2*RD_LAT+1 -: 2] == TAG_DRAW;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between display scan-out and the draw engine
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              draw_req,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT - 1);
  logic [1:0] state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic force_go;
  tag_t tag;
  logic [DATA_W-1:0] disp_hold, draw_hold;
  // region priority picks the winner; the forced slot locks the display out for one cycle
  always_comb begin
    draw_gnt = rst_n & draw_req & ((state != ST_ACTIVE) | ~disp_req);
    disp_gnt = rst_n & disp_req & ((state == ST_ACTIVE) | ((state == ST_BLANK) & ~draw_req));
    force_go = (state == ST_ACTIVE) & draw_req & ~draw_gnt & (wait_cnt == WMAX);
    state_nx = force_go ? ST_FORCE : active ? ST_ACTIVE : ST_BLANK;
    tag = disp_gnt ? TAG_DISP : (draw_gnt & ~draw_we) ? TAG_DRAW : TAG_NONE;
  end
  // region state, draw starvation counter and the registered VRAM command
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_BLANK;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= (!draw_req || draw_gnt) ? '0 : (wait_cnt == WMAX) ? wait_cnt : wait_cnt + 1'b1;
      mem_en    <= disp_gnt | draw_gnt;
      mem_we    <= draw_gnt & draw_we;
      if (disp_gnt | draw_gnt) mem_addr <= draw_gnt ? draw_addr : disp_addr;
      if (draw_gnt) mem_wdata <= draw_wdata;
    end
  // each requester keeps its last returned pixel until its next return
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp_hold <= '0;
      draw_hold <= '0;
    end else begin
      if (disp_rvalid) disp_hold <= mem_rdata;
      if (draw_rvalid) draw_hold <= mem_rdata;
    end
  assign disp_rdata = disp_rvalid ? mem_rdata : disp_hold;
  assign draw_rdata = draw_rvalid ? mem_rdata : draw_hold;
  vram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .tag         (tag),
    .disp_rvalid (disp_rvalid),
    .draw_rvalid (draw_rvalid)
  );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors and corner sequences on two arbiter configurations
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic active = 1'b0, disp_req = 1'b0, draw_req = 1'b0, draw_we = 1'b0;
  logic [AW-1:0] disp_addr = '0, draw_addr = '0;
  logic [DW-1:0] draw_wdata = '0;
  logic dg1, dv1, wg1, wv1, me1, mw1;
  logic [DW-1:0] dd1, wd1, mwd1, mr1;
  logic [AW-1:0] ma1;
  logic dg3, dv3, wg3, wv3, me3, mw3;
  logic [DW-1:0] dd3, wd3, mwd3, mr3;
  logic [AW-1:0] ma3;
  logic [DW-1:0] p1, p3a, p3b, p3c;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_WAIT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .active(active),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(dg1), .disp_rvalid(dv1), .disp_rdata(dd1),
    .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_gnt(wg1), .draw_rvalid(wv1), .draw_rdata(wd1),
    .mem_en(me1), .mem_we(mw1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mr1)
  );

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_WAIT(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .active(active),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(dg3), .disp_rvalid(dv3), .disp_rdata(dd3),
    .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_gnt(wg3), .draw_rvalid(wv3), .draw_rdata(wd3),
    .mem_en(me3), .mem_we(mw3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(mr3)
  );

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return DW'(32'(a) * 32'd37 + 32'd5);
  endfunction

  // behavioural VRAMs: read data appears RD_LAT cycles after the mem_en cycle
  always @(posedge clk) begin
    p1  <= (me1 && !mw1) ? pix(ma1) : 8'hEE;
    p3a <= (me3 && !mw3) ? pix(ma3) : 8'hEE;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mr1 = p1;
  assign mr3 = p3c;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic dr, input logic wr, input logic we,
                       input logic [AW-1:0] da, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    active = a; disp_req = dr; draw_req = wr; draw_we = we;
    disp_addr = da; draw_addr = wa; draw_wdata = wd;
  endtask

  typedef struct {
    logic a, dr, wr, we;
    logic [AW-1:0] da, wa;
    logic [DW-1:0] wd;
    logic edg, ewg, een, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
  } vec_t;
  vec_t tv[8];

  initial begin
    tv[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h10, 19'h123, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 19'h123, 8'hA5};
    tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h10, 19'h123, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 19'h10,  8'hA5};
    tv[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h10, 19'h123, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 19'h10,  8'hA5};
    tv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h20, 19'h55,  8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 19'h55,  8'h5A};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h20, 19'h55,  8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 19'h20,  8'h5A};
    tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h20, 19'h77,  8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 19'h77,  8'h3C};
    tv[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h21, 19'h78,  8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 19'h21,  8'h3C};
    tv[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h21, 19'h78,  8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 19'h78,  8'h11};

    #3;
    chk("reset_outs1", {dg1, dv1, dd1, wg1, wv1, wd1, me1, mw1, ma1, mwd1}, 0);
    chk("reset_outs3", {dg3, dv3, dd3, wg3, wv3, wd3, me3, mw3, ma3, mwd3}, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].a, tv[i].dr, tv[i].wr, tv[i].we, tv[i].da, tv[i].wa, tv[i].wd);
      #4;
      chk($sformatf("vec%0d_disp_gnt", i), dg1, tv[i].edg);
      chk($sformatf("vec%0d_draw_gnt", i), wg1, tv[i].ewg);
      tick;
      chk($sformatf("vec%0d_mem_en", i), me1, tv[i].een);
      chk($sformatf("vec%0d_mem_we", i), mw1, tv[i].ewe);
      chk($sformatf("vec%0d_mem_addr", i), ma1, tv[i].ea);
      chk($sformatf("vec%0d_mem_wdata", i), mwd1, tv[i].ewd);
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, AW'(32'h100 + i), 19'h200, 8'h00);
      #4;
      chk("conflict_disp_gnt", dg1, 1);
      chk("conflict_draw_gnt", wg1, 0);
      tick;
      chk("conflict_mem_addr", ma1, AW'(32'h100 + i));
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(i >= 1, 1'b1, 1'b1, 1'b0, 19'h40, 19'h41, 8'h00);
      #4;
      chk("edge_disp_gnt1", dg1, i >= 2);
      chk("edge_draw_gnt1", wg1, i < 2);
      chk("edge_both1", dg1 & wg1, 0);
      chk("edge_both3", dg3 & wg3, 0);
      tick;
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick;
    for (int i = 0; i < 27; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 19'h300, 19'h301, 8'h00);
      #4;
      chk($sformatf("starve%0d_draw_gnt", i), wg3, (i % 9) == 8);
      chk($sformatf("starve%0d_disp_gnt", i), dg3, (i % 9) != 8);
      tick;
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick;
    for (int i = 0; i < 10; i++) begin
      drive(i < 7, 1'b1, i != 8, 1'b0, 19'h310, 19'h311, 8'h00);
      #4;
      chk($sformatf("prec%0d_disp_gnt", i), dg3, i < 8);
      chk($sformatf("prec%0d_draw_gnt", i), wg3, i == 9);
      tick;
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) tick;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, k < 8, 1'b0, 1'b0, AW'(k), '0, '0);
      #4;
      chk($sformatf("lat1_rvalid%0d", k), dv1, k >= 2 && k < 10);
      if (k >= 2 && k < 10) chk($sformatf("lat1_rdata%0d", k), dd1, pix(AW'(k - 2)));
      chk($sformatf("lat3_rvalid%0d", k), dv3, k >= 4 && k < 12);
      if (k >= 4 && k < 12) chk($sformatf("lat3_rdata%0d", k), dd3, pix(AW'(k - 4)));
      chk("lat_draw_rvalid", wv1, 0);
      tick;
    end
    chk("hold_rdata1", dd1, pix(AW'(7)));
    chk("hold_rdata3", dd3, pix(AW'(7)));

    drive(1'b1, 1'b1, 1'b0, 1'b0, 19'h5, '0, '0);
    #4;
    chk("rst_read_gnt", dg1, 1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs1", {dg1, dv1, dd1, wg1, wv1, wd1, me1, mw1, ma1, mwd1}, 0);
    chk("midrst_outs3", {dg3, dv3, dd3, wg3, wv3, wd3, me3, mw3, ma3, mwd3}, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      #4;
      chk("dropped_rvalid1", dv1, 0);
      chk("dropped_rvalid3", dv3, 0);
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
